pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 16'd4096, consecutive-stall cycles before timeout flag.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset (rst==0 resets on clk edge).
REQ-004 SHALL have port stallreq_if_i  input  1  icache miss, fetch not ready.
REQ-005 SHALL have port stallreq_of_i  input  1  operand-fetch load-use dependency.
REQ-006 SHALL have port stallreq_ex_i  input  1  multi-cycle mul/div busy.
REQ-007 SHALL have port stallreq_mem_i  input  1  dcache miss / bus wait.
REQ-008 SHALL have port exception_i  input  1  commit-stage exception or eret, level, held until flushed.
REQ-009 SHALL have port exception_pc_i  input  32  handler/EPC target, valid with exception_i.
REQ-010 SHALL have port stall_o  output  6  per-boundary stall: bit0 pc, bit1 if/id, bit2 id/of, bit3 of/ex, bit4 ex/mem, bit5 mem/commit.
REQ-011 SHALL have port flush_o  output  1  flush all pipeline registers this cycle.
REQ-012 SHALL have port new_pc_o  output  32  redirect PC, valid when flush_o=1, else 0.
REQ-013 SHALL have port stall_timeout_o  output  1  sticky, stall exceeded STALL_LIMIT.
REQ-014 SHALL have port stall_cycles_o  output  32  saturating count of cycles with stall_o!=0.
REQ-015 SHALL have port flush_count_o  output  16  wrapping count of flush_o pulses.

Function
REQ-016 stall_o SHALL be combinational, priority mem>ex>of>if: mem 6'b011111; ex 6'b001111; of 6'b000111; if 6'b000011; none 6'b000000.
REQ-017 Lowest unstalled stage boundary SHALL receive a bubble (downstream registers load NOP); bit5 never set.
REQ-018 FSM states RUN, HOLD_EXC; reset state RUN.
REQ-019 RUN, exception_i=1, stallreq_mem_i=0: flush_o=1 same cycle, new_pc_o=exception_pc_i, stall_o=0 (flush overrides of/ex/if stalls), stay RUN.
REQ-020 RUN, exception_i=1, stallreq_mem_i=1: flush_o=0, stall_o=6'b011111, latch exception_pc_i into pend_pc, go HOLD_EXC.
REQ-021 HOLD_EXC, stallreq_mem_i=1: stall_o=6'b011111, flush_o=0, remain.
REQ-022 HOLD_EXC, stallreq_mem_i=0: flush_o=1, new_pc_o=pend_pc (latched value, not live input), stall_o=0, go RUN.
REQ-023 flush_o SHALL be exactly one cycle per accepted exception; exception_i still high the cycle after flush SHALL be treated as a new exception.
REQ-024 stall counter (16 bit) SHALL increment each cycle stall_o!=0, clear on any cycle stall_o==0 or flush_o=1, saturate at 16'hFFFF.
REQ-025 When stall counter == STALL_LIMIT-1 and stall persists, stall_timeout_o SHALL set next edge and hold until reset.
REQ-026 stall_cycles_o SHALL increment when stall_o!=0, saturate at 32'hFFFFFFFF.
REQ-027 flush_count_o SHALL increment on each flush_o cycle, wrap 16'hFFFF->0.
REQ-028 Counters, pend_pc, state SHALL update only on clk rising edge; stall_o, flush_o, new_pc_o derived combinationally from state and inputs.

Reset
REQ-029 rst==0 at edge: state RUN, pend_pc=0, stall counter=0, stall_timeout_o=0, stall_cycles_o=0, flush_count_o=0.
REQ-030 While rst==0, stall_o=0, flush_o=0, new_pc_o=0 regardless of inputs.
REQ-031 Reset asserted in HOLD_EXC SHALL drop pending exception; no flush after release.

Verification
REQ-032 stallreq_of_i=1 and stallreq_if_i=1 for 3 cycles -> stall_o=6'b000111 each cycle, stall_cycles_o=3, flush_o=0.
REQ-033 exception_i=1, exception_pc_i=32'hBFC00380, no stalls -> flush_o=1 same cycle, new_pc_o=32'hBFC00380, stall_o=0, flush_count_o=1 next cycle.
REQ-034 stallreq_mem_i=1 for 4 cycles, exception_i rises cycle 1 with 32'h80000180 then input changes to 0 -> stall_o=6'b011111 cycles 1-4, flush_o=1 in cycle 5 with new_pc_o=32'h80000180.
REQ-035 STALL_LIMIT=8, stallreq_ex_i held 10 cycles -> stall_timeout_o rises after 8th stalled cycle, stays 1 after stall clears.
REQ-036 rst=0 during HOLD_EXC, then rst=1, stallreq_mem_i=0 -> no flush_o, all counters 0.
REQ-037 flush_count_o preset by 65535 exceptions -> next flush wraps count to 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Hazard-request / redirect bundle between the pipeline stages and pipe_ctrl.
// master drives the stall requests and exception; slave (pipe_ctrl) drives stall/flush/redirect.
interface pipe_ctrl_if;
   logic        stallreq_if_i;
   logic        stallreq_of_i;
   logic        stallreq_ex_i;
   logic        stallreq_mem_i;
   logic        exception_i;
   logic [31:0] exception_pc_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        stall_timeout_o;
   logic [31:0] stall_cycles_o;
   logic [15:0] flush_count_o;

   modport master (
      output stallreq_if_i, stallreq_of_i, stallreq_ex_i, stallreq_mem_i,
      output exception_i, exception_pc_i,
      input  stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cycles_o, flush_count_o
   );

   modport slave (
      input  stallreq_if_i, stallreq_of_i, stallreq_ex_i, stallreq_mem_i,
      input  exception_i, exception_pc_i,
      output stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cycles_o, flush_count_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritised per-boundary stalls, exception flush/redirect
// (deferred while a memory stall is outstanding), stall timeout and activity counters.
module pipe_ctrl #(
   parameter logic [15:0] STALL_LIMIT = 16'd4096
) (
   input  logic       clk,
   input  logic       rst,
   pipe_ctrl_if.slave bus
);

   localparam int unsigned PC_W   = 32;
   localparam int unsigned STL_W  = 6;
   localparam int unsigned SCNT_W = 16;
   localparam int unsigned CYC_W  = 32;
   localparam int unsigned FCNT_W = 16;

   localparam logic [STL_W-1:0]  STALL_MEM = 6'b011111;
   localparam logic [STL_W-1:0]  STALL_EX  = 6'b001111;
   localparam logic [STL_W-1:0]  STALL_OF  = 6'b000111;
   localparam logic [STL_W-1:0]  STALL_IF  = 6'b000011;
   localparam logic [SCNT_W-1:0] LIMIT_M1  = SCNT_W'(STALL_LIMIT - 16'd1);

   typedef enum logic {RUN = 1'b0, HOLD_EXC = 1'b1} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [PC_W-1:0]     pend_pc;
   logic [SCNT_W-1:0]   stall_cnt;
   logic                timeout_q;
   logic [CYC_W-1:0]    stall_cycles_q;
   logic [FCNT_W-1:0]   flush_count_q;

   logic [STL_W-1:0]    stall_c;
   logic                flush_c;
   logic [PC_W-1:0]     new_pc_c;
   logic                latch_pc_c;
   logic [STL_W-1:0]    prio_stall_c;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= RUN;
      else      state <= state_nxt;
   end

   // Next-state: an exception arriving under a memory stall is parked until the stall drains
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (bus.exception_i && bus.stallreq_mem_i) state_nxt = HOLD_EXC;
         HOLD_EXC: if (!bus.stallreq_mem_i)                   state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase
   end

   // Stall priority: deepest requesting stage freezes itself and everything upstream
   always_comb begin
      prio_stall_c = '0;
      if      (bus.stallreq_mem_i) prio_stall_c = STALL_MEM;
      else if (bus.stallreq_ex_i)  prio_stall_c = STALL_EX;
      else if (bus.stallreq_of_i)  prio_stall_c = STALL_OF;
      else if (bus.stallreq_if_i)  prio_stall_c = STALL_IF;
   end

   // Outputs: flush wins over non-mem stalls; everything forced quiet while in reset
   always_comb begin
      stall_c    = '0;
      flush_c    = 1'b0;
      new_pc_c   = '0;
      latch_pc_c = 1'b0;
      if (rst) begin
         case (state)
            RUN: begin
               if (bus.exception_i) begin
                  if (bus.stallreq_mem_i) begin
                     stall_c    = STALL_MEM;
                     latch_pc_c = 1'b1;
                  end else begin
                     flush_c  = 1'b1;
                     new_pc_c = bus.exception_pc_i;
                  end
               end else begin
                  stall_c = prio_stall_c;
               end
            end
            HOLD_EXC: begin
               if (bus.stallreq_mem_i) begin
                  stall_c = STALL_MEM;
               end else begin
                  flush_c  = 1'b1;
                  new_pc_c = pend_pc;
               end
            end
            default: ;
         endcase
      end
   end

   // Pending PC, stall watchdog and activity counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_pc        <= '0;
         stall_cnt      <= '0;
         timeout_q      <= 1'b0;
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if (latch_pc_c) pend_pc <= bus.exception_pc_i;

         if (flush_c || (stall_c == '0))  stall_cnt <= '0;
         else if (stall_cnt != '1)        stall_cnt <= stall_cnt + SCNT_W'(1);

         if ((stall_c != '0) && (stall_cnt == LIMIT_M1)) timeout_q <= 1'b1;

         if ((stall_c != '0) && (stall_cycles_q != '1))
            stall_cycles_q <= stall_cycles_q + CYC_W'(1);

         if (flush_c) flush_count_q <= flush_count_q + FCNT_W'(1);
      end
   end

   assign bus.stall_o         = stall_c;
   assign bus.flush_o         = flush_c;
   assign bus.new_pc_o        = new_pc_c;
   assign bus.stall_timeout_o = timeout_q;
   assign bus.stall_cycles_o  = stall_cycles_q;
   assign bus.flush_count_o   = flush_count_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle expected stall/flush/redirect go through a
// scoreboard queue; counters and timeout are checked inline at the end of each scenario.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic rst;
   pipe_ctrl_if bus();

   pipe_ctrl #(.STALL_LIMIT(16'd8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // Apply one cycle of inputs just after the edge, queue its expectation, settle to mid-cycle
   task automatic drive(input logic r, input logic [3:0] req, input logic exc,
                        input logic [31:0] epc, input logic [5:0] es, input logic ef,
                        input logic [31:0] ep);
      exp_t e;
      @(posedge clk); #1;
      rst                = r;
      bus.stallreq_mem_i = req[3];
      bus.stallreq_ex_i  = req[2];
      bus.stallreq_of_i  = req[1];
      bus.stallreq_if_i  = req[0];
      bus.exception_i    = exc;
      bus.exception_pc_i = epc;
      e.stall = es; e.flush = ef; e.pc = ep;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic do_reset;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.stallreq_mem_i = 1'b0; bus.stallreq_ex_i = 1'b0;
      bus.stallreq_of_i  = 1'b0; bus.stallreq_if_i = 1'b0;
      bus.exception_i = 1'b0; bus.exception_pc_i = '0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_reset;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 4'b1111, 1'b1, 32'hFFFF_FFFF, 6'b0, 1'b0, 32'h0);
         e = sb.pop_front();
         checks++;
         if (bus.stall_o !== e.stall || bus.flush_o !== e.flush || bus.new_pc_o !== e.pc) begin
            failures++;
            $display("FAIL reset_outputs[%0d]: got stall=%b flush=%b pc=%h, need stall=%b flush=%b pc=%h",
                     i, bus.stall_o, bus.flush_o, bus.new_pc_o, e.stall, e.flush, e.pc);
         end
      end
      checks++;
      if (bus.stall_timeout_o !== 1'b0 || bus.stall_cycles_o !== 32'd0 || bus.flush_count_o !== 16'd0) begin
         failures++;
         $display("FAIL reset_counters: got to=%b cyc=%0d fc=%0d, need 0 0 0",
                  bus.stall_timeout_o, bus.stall_cycles_o, bus.flush_count_o);
      end
   endtask

   task automatic test_priority;
      exp_t e;
      logic [3:0] reqs[10];
      logic [5:0] exps[10];
      reqs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
               4'b0011, 4'b0110, 4'b1111, 4'b1010, 4'b0000};
      exps = '{6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b000000,
               6'b000111, 6'b001111, 6'b011111, 6'b011111, 6'b000000};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, reqs[i], 1'b0, 32'h0, exps[i], 1'b0, 32'h0);
         e = sb.pop_front();
         checks++;
         if (bus.stall_o !== e.stall || bus.flush_o !== e.flush || bus.new_pc_o !== e.pc) begin
            failures++;
            $display("FAIL priority[%0d]: got stall=%b flush=%b pc=%h, need stall=%b flush=%b pc=%h",
                     i, bus.stall_o, bus.flush_o, bus.new_pc_o, e.stall, e.flush, e.pc);
         end
      end
      checks++;
      if (bus.stall_cycles_o !== 32'd8 || bus.stall_timeout_o !== 1'b0) begin
         failures++;
         $display("FAIL priority_counters: got cyc=%0d to=%b, need cyc=8 to=0",
                  bus.stall_cycles_o, bus.stall_timeout_o);
      end
   endtask

   task automatic test_of_if_stall;
      exp_t e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive(1'b1, 4'b0011, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0);
         else       drive(1'b1, 4'b0000, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0);
         e = sb.pop_front();
         checks++;
         if (bus.stall_o !== e.stall || bus.flush_o !== e.flush || bus.new_pc_o !== e.pc) begin
            failures++;
            $display("FAIL of_if_stall[%0d]: got stall=%b flush=%b pc=%h, need stall=%b flush=%b pc=%h",
                     i, bus.stall_o, bus.flush_o, bus.new_pc_o, e.stall, e.flush, e.pc);
         end
      end
      checks++;
      if (bus.stall_cycles_o !== 32'd3 || bus.flush_count_o !== 16'd0) begin
         failures++;
         $display("FAIL of_if_counters: got cyc=%0d fc=%0d, need cyc=3 fc=0",
                  bus.stall_cycles_o, bus.flush_count_o);
      end
   endtask

   task automatic test_exception;
      exp_t e;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: drive(1'b1, 4'b0000, 1'b1, 32'hBFC0_0380, 6'b0, 1'b1, 32'hBFC0_0380);
            1: drive(1'b1, 4'b0000, 1'b0, 32'h0,         6'b0, 1'b0, 32'h0);
            2: drive(1'b1, 4'b0110, 1'b1, 32'h1234_5678, 6'b0, 1'b1, 32'h1234_5678);
            3: drive(1'b1, 4'b0000, 1'b1, 32'h1234_5678, 6'b0, 1'b1, 32'h1234_5678);
            default: drive(1'b1, 4'b0000, 1'b0, 32'h0,   6'b0, 1'b0, 32'h0);
         endcase
         e = sb.pop_front();
         checks++;
         if (bus.stall_o !== e.stall || bus.flush_o !== e.flush || bus.new_pc_o !== e.pc) begin
            failures++;
            $display("FAIL exception[%0d]: got stall=%b flush=%b pc=%h, need stall=%b flush=%b pc=%h",
                     i, bus.stall_o, bus.flush_o, bus.new_pc_o, e.stall, e.flush, e.pc);
         end
         if (i == 1) begin
            checks++;
            if (bus.flush_count_o !== 16'd1) begin
               failures++;
               $display("FAIL exception_fc1: got fc=%0d, need 1", bus.flush_count_o);
            end
         end
      end
      checks++;
      if (bus.flush_count_o !== 16'd3 || bus.stall_cycles_o !== 32'd0) begin
         failures++;
         $display("FAIL exception_counters: got fc=%0d cyc=%0d, need fc=3 cyc=0",
                  bus.flush_count_o, bus.stall_cycles_o);
      end
   endtask

   task automatic test_mem_hold;
      exp_t e;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: drive(1'b1, 4'b1000, 1'b1, 32'h8000_0180, 6'b011111, 1'b0, 32'h0);
            1, 2, 3: drive(1'b1, 4'b1000, 1'b0, 32'h0,   6'b011111, 1'b0, 32'h0);
            4: drive(1'b1, 4'b0100, 1'b0, 32'hDEAD_BEEF, 6'b000000, 1'b1, 32'h8000_0180);
            default: drive(1'b1, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0);
         endcase
         e = sb.pop_front();
         checks++;
         if (bus.stall_o !== e.stall || bus.flush_o !== e.flush || bus.new_pc_o !== e.pc) begin
            failures++;
            $display("FAIL mem_hold[%0d]: got stall=%b flush=%b pc=%h, need stall=%b flush=%b pc=%h",
                     i, bus.stall_o, bus.flush_o, bus.new_pc_o, e.stall, e.flush, e.pc);
         end
      end
      checks++;
      if (bus.flush_count_o !== 16'd1 || bus.stall_cycles_o !== 32'd4) begin
         failures++;
         $display("FAIL mem_hold_counters: got fc=%0d cyc=%0d, need fc=1 cyc=4",
                  bus.flush_count_o, bus.stall_cycles_o);
      end
   endtask

   task automatic test_timeout;
      exp_t e;
      logic stall_on;
      logic exp_to;
      do_reset();
      // 7 stalls, gap, 7 stalls, gap, 10 stalls, gap; limit is 8
      for (int i = 0; i < 27; i++) begin
         stall_on = !(i == 7 || i == 15 || i == 26);
         exp_to   = (i >= 24);
         if (stall_on) drive(1'b1, 4'b0100, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0);
         else          drive(1'b1, 4'b0000, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0);
         e = sb.pop_front();
         checks++;
         if (bus.stall_o !== e.stall || bus.flush_o !== e.flush || bus.new_pc_o !== e.pc) begin
            failures++;
            $display("FAIL timeout_stall[%0d]: got stall=%b flush=%b pc=%h, need stall=%b flush=%b pc=%h",
                     i, bus.stall_o, bus.flush_o, bus.new_pc_o, e.stall, e.flush, e.pc);
         end
         checks++;
         if (bus.stall_timeout_o !== exp_to) begin
            failures++;
            $display("FAIL timeout_flag[%0d]: got %b, need %b", i, bus.stall_timeout_o, exp_to);
         end
      end
      checks++;
      if (bus.stall_cycles_o !== 32'd24) begin
         failures++;
         $display("FAIL timeout_cycles: got %0d, need 24", bus.stall_cycles_o);
      end
   endtask

   task automatic test_reset_in_hold;
      exp_t e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: drive(1'b1, 4'b1000, 1'b1, 32'h8000_0180, 6'b011111, 1'b0, 32'h0);
            1: drive(1'b0, 4'b1000, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0);
            default: drive(1'b1, 4'b0000, 1'b0, 32'h0,   6'b000000, 1'b0, 32'h0);
         endcase
         e = sb.pop_front();
         checks++;
         if (bus.stall_o !== e.stall || bus.flush_o !== e.flush || bus.new_pc_o !== e.pc) begin
            failures++;
            $display("FAIL reset_in_hold[%0d]: got stall=%b flush=%b pc=%h, need stall=%b flush=%b pc=%h",
                     i, bus.stall_o, bus.flush_o, bus.new_pc_o, e.stall, e.flush, e.pc);
         end
      end
      checks++;
      if (bus.stall_cycles_o !== 32'd0 || bus.flush_count_o !== 16'd0 || bus.stall_timeout_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_hold_counters: got cyc=%0d fc=%0d to=%b, need 0 0 0",
                  bus.stall_cycles_o, bus.flush_count_o, bus.stall_timeout_o);
      end
   endtask

   task automatic test_flush_wrap;
      do_reset();
      @(posedge clk); #1;
      bus.exception_i    = 1'b1;
      bus.exception_pc_i = 32'hA000_0000;
      repeat (65535) @(posedge clk);
      #1;
      checks++;
      if (bus.flush_count_o !== 16'hFFFF || bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'hA000_0000) begin
         failures++;
         $display("FAIL flush_wrap_pre: got fc=%h flush=%b pc=%h, need fc=ffff flush=1 pc=a0000000",
                  bus.flush_count_o, bus.flush_o, bus.new_pc_o);
      end
      @(posedge clk); #1;
      bus.exception_i = 1'b0;
      checks++;
      if (bus.flush_count_o !== 16'h0000) begin
         failures++;
         $display("FAIL flush_wrap: got fc=%h, need 0000", bus.flush_count_o);
      end
      @(negedge clk);
      checks++;
      if (bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0) begin
         failures++;
         $display("FAIL flush_wrap_idle: got flush=%b pc=%h, need flush=0 pc=0",
                  bus.flush_o, bus.new_pc_o);
      end
   endtask

   initial begin
      rst = 1'b0;
      bus.stallreq_mem_i = 1'b0; bus.stallreq_ex_i = 1'b0;
      bus.stallreq_of_i  = 1'b0; bus.stallreq_if_i = 1'b0;
      bus.exception_i = 1'b0; bus.exception_pc_i = '0;
      test_reset();
      test_priority();
      test_of_if_stall();
      test_exception();
      test_mem_hold();
      test_timeout();
      test_reset_in_hold();
      test_flush_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
